fifo_wr_arbiter: RTL



---
 rtl/fifo_arb_pkg.sv | 48 ++++
 rtl/rr_priority_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Combinational helpers only; no latency of their own.
// No backpressure handling here; callers own the handshake.
package fifo_arb_pkg;

  // Upper bound on requesters; the pick helper works on vectors of this width.
  localparam int MAX_REQ  = 8;
  localparam int ID_MAX_W = 3;

  typedef enum logic {IDLE, GRANT} state_t;

  typedef struct packed {
    logic                found;
    logic [ID_MAX_W-1:0] id;
  } pick_t;

  // Width of a requester index; a single requester still needs one bit.
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width of a beat counter able to hold 0..max_burst.
  function automatic int cnt_w(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

  // Round-robin pick: first valid id scanning upward from last_id+1, wrapping at n.
  // The wrap is an explicit compare so n need not be a power of two.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input int                 n,
                                    input logic [ID_MAX_W-1:0] last_id);
    pick_t r;
    int    idx;
    r = '0;
    for (int k = 1; k <= MAX_REQ; k++) begin
      if (k <= n && !r.found) begin
        idx = int'(last_id) + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx]) begin
          r.found = 1'b1;
          r.id    = ID_MAX_W'(idx);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotate-and-priority-encode of NUM_REQ valid bits starting after last_id.
// Purely combinational, zero latency.
// No backpressure; result is valid whenever inputs are stable.
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     last_id_i,
  output logic [IDW-1:0]     id_o,
  output logic               found_o
);

  logic [MAX_REQ-1:0] valid_pad;
  pick_t              pick;

  // Widen to the helper's fixed width and run the round-robin scan.
  always_comb begin
    valid_pad                = '0;
    valid_pad[NUM_REQ-1:0]   = valid_i;
    pick                     = rr_pick(valid_pad, NUM_REQ, ID_MAX_W'(last_id_i));
  end

  assign found_o = pick.found;
  assign id_o    = IDW'(pick.id);

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin share of one FIFO write port among NUM_REQ producers, bursts up to MAX_BURST.
// One idle cycle to arbitrate; granted beats reach wr_en in the same cycle as the handshake.
// FIFO full stalls the granted producer (req_ready low) without releasing the grant.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      full,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy
);

  localparam int IDW = id_w(NUM_REQ);
  localparam int CW  = cnt_w(MAX_BURST);

  state_t             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDW-1:0]     gid_q;
  logic [CW-1:0]      cnt_q;
  logic [IDW-1:0]     last_q;

  logic [IDW-1:0]     pick_id;
  logic               pick_found;
  logic               g_valid;
  logic [DATA_W-1:0]  g_data;
  logic               active;
  logic               xfer;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .valid_i   (req_valid),
    .last_id_i (last_q),
    .id_o      (pick_id),
    .found_o   (pick_found)
  );

  // Mux the granted requester's valid/data and drive the outputs; all forced low in reset.
  always_comb begin
    g_valid = 1'b0;
    g_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gid_q == IDW'(i)) begin
        g_valid = req_valid[i];
        g_data  = req_data[i*DATA_W +: DATA_W];
      end
    end
    active    = (state_q == GRANT) && !rst;
    xfer      = active && g_valid && !full;
    wr_en     = xfer;
    wr_data   = xfer ? g_data : '0;
    busy      = active;
    grant     = active ? grant_q : '0;
    req_ready = (active && !full) ? grant_q : '0;
  end

  // Arbitration FSM: pick in IDLE, count beats in GRANT, release on last beat or dropped valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
      last_q  <= IDW'(NUM_REQ - 1);
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            state_q <= GRANT;
            gid_q   <= pick_id;
            grant_q <= NUM_REQ'(1) << pick_id;
            cnt_q   <= '0;
          end
        end
        GRANT: begin
          if (!g_valid || (xfer && cnt_q == CW'(MAX_BURST - 1))) begin
            state_q <= IDLE;
            last_q  <= gid_q;
            grant_q <= '0;
            cnt_q   <= '0;
          end else if (xfer) begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

endmodule
